// File: rtl/ysyx_25020032_icache.sv
// Direct-mapped, one-word-per-line instruction cache between the IFU AXI read port and the system AXI read bus.
// Hit: s_rvalid two cycles after the AR handshake; miss: single-beat downstream fetch, then forward; one transaction in flight.
module ysyx_25020032_icache #(
    parameter int          INDEX_BITS = 4,
    parameter logic [31:0] CACHE_LO   = 32'h80000000,
    parameter logic [31:0] CACHE_HI   = 32'h87ffffff
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_arid,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,

    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic [3:0]  s_rid,

    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,

    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic [3:0]  m_rid,

    input  logic        fence_i,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, RESP} state_t;

    state_t                state;
    logic [31:0]           addr;
    logic [3:0]            id;
    logic                  fence_pend;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags  [LINES];
    logic [31:0]           lines [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  cacheable;
    logic                  hit;
    logic                  r_fire;
    logic                  fill;
    logic                  unused_inputs;

    assign idx       = addr[INDEX_BITS+1:2];
    assign tag       = addr[31:INDEX_BITS+2];
    assign cacheable = (addr >= CACHE_LO) && (addr <= CACHE_HI);
    // A fence sampled in the lookup cycle forces a miss.
    assign hit       = cacheable && valid[idx] && (tags[idx] == tag) && !fence_i;
    assign r_fire    = (state == MISS_R) && m_rvalid && m_rready;
    assign fill      = r_fire && cacheable && (m_rresp == 2'b00) && !fence_pend && !fence_i;

    assign s_arready = (state == IDLE);
    assign s_rlast   = 1'b1;
    assign m_arlen   = 8'd0;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;

    assign unused_inputs = ^{s_arlen, s_arsize, s_arburst, m_rid, m_rlast};

    always_ff @(posedge clk) begin
        if (fill) begin
            tags[idx]  <= tag;
            lines[idx] <= m_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            id         <= '0;
            fence_pend <= 1'b0;
            valid      <= '0;
            s_rvalid   <= 1'b0;
            s_rdata    <= '0;
            s_rresp    <= '0;
            s_rid      <= '0;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_arid     <= '0;
            m_rready   <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            if (fence_i) begin
                valid <= '0;
            end else if (fill) begin
                valid[idx] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    fence_pend <= 1'b0;
                    if (s_arvalid) begin
                        addr  <= s_araddr;
                        id    <= s_arid;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        s_rdata  <= lines[idx];
                        s_rresp  <= 2'b00;
                        s_rid    <= id;
                        s_rvalid <= 1'b1;
                        hit_cnt  <= hit_cnt + 32'd1;
                        state    <= RESP;
                    end else begin
                        m_araddr  <= {addr[31:2], 2'b00};
                        m_arid    <= id;
                        m_arvalid <= 1'b1;
                        if (cacheable) begin
                            miss_cnt <= miss_cnt + 32'd1;
                        end
                        state <= MISS_AR;
                    end
                end
                MISS_AR: begin
                    if (fence_i) begin
                        fence_pend <= 1'b1;
                    end
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= MISS_R;
                    end
                end
                MISS_R: begin
                    if (fence_i) begin
                        fence_pend <= 1'b1;
                    end
                    if (r_fire) begin
                        m_rready <= 1'b0;
                        s_rdata  <= m_rdata;
                        s_rresp  <= m_rresp;
                        s_rid    <= id;
                        s_rvalid <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25020032_icache.sv
// Randomized bench for the icache: a downstream memory responder plus a word-address cache model
// that predicts data, response, fetch traffic, latency and counters for every read.
module tb_ysyx_25020032_icache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_arvalid = 1'b0, s_arready;
    logic [31:0] s_araddr = '0;
    logic [3:0]  s_arid = '0;
    logic [7:0]  s_arlen = '0;
    logic [2:0]  s_arsize = '0;
    logic [1:0]  s_arburst = '0;
    logic        s_rvalid, s_rready = 1'b0, s_rlast;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [3:0]  s_rid;
    logic        m_arvalid, m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid = 1'b0, m_rready, m_rlast = 1'b1;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic [3:0]  m_rid = '0;
    logic        fence_i = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    ysyx_25020032_icache dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .fence_i(fence_i), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing memory: unwritten words hold an address-derived pattern.
    logic [31:0] mem [logic [29:0]];
    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return {wa, 2'b00} ^ 32'h13579bdf;
    endfunction

    int          ar_cnt = 0;
    logic [31:0] ar_addr_seen = '0;
    logic [3:0]  ar_id_seen = '0;
    logic        err_next = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_arvalid && !rst) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                m_arready    = 1'b1;
                ar_addr_seen = m_araddr;
                ar_id_seen   = m_arid;
                ar_cnt++;
                @(negedge clk);
                m_arready = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                m_rvalid = 1'b1;
                m_rdata  = mem_rd(ar_addr_seen[31:2]);
                m_rresp  = err_next ? 2'b10 : 2'b00;
                m_rid    = ar_id_seen;
                @(negedge clk);
                m_rvalid = 1'b0;
            end
        end
    end

    // Model: each index remembers which word address it holds and that word's data.
    bit          mv  [16];
    logic [29:0] mwa [16];
    logic [31:0] md  [16];
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;
    logic [31:0] last_data;
    logic [1:0]  last_resp;

    function automatic bit is_cacheable(input logic [31:0] a);
        return (a >= 32'h80000000) && (a <= 32'h87ffffff);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    task automatic pulse_fence();
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
        clear_model();
    endtask

    // fence_k > 0: pulse fence at that cycle after the handshake; -1: pulse while m_rready is up.
    task automatic do_read(input logic [31:0] a, input int fence_k, input int hold);
        logic [3:0]  id;
        logic [29:0] wa;
        logic [3:0]  ix;
        logic [31:0] exp_data, held;
        logic [1:0]  exp_resp;
        bit          f_seen, f_lookup, f_miss, exp_hit, done, cach;
        int          n, ar0;
        id = 4'($urandom);
        wa = a[31:2];
        ix = a[5:2];
        ar0 = ar_cnt;
        f_seen = 0; f_lookup = 0; f_miss = 0; done = 0;
        cach = is_cacheable(a);
        s_arvalid = 1'b1;
        s_araddr  = a;
        s_arid    = id;
        s_arlen   = 8'($urandom);
        s_arsize  = 3'($urandom);
        s_arburst = 2'($urandom);
        chk("arready_idle", s_arready, 1);
        @(negedge clk);
        s_arvalid = 1'b0;
        for (n = 1; n < 80; n++) begin
            fence_i = 1'b0;
            if (!f_seen && (n == fence_k || (fence_k < 0 && m_rready))) begin
                fence_i  = 1'b1;
                f_seen   = 1;
                f_lookup = (n == 1);
                f_miss   = m_arvalid || m_rready;
            end
            if (s_rvalid) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            fence_i = 1'b0;
            chk("rvalid_timeout", 0, 1);
            return;
        end
        if (f_lookup) clear_model();
        exp_hit = cach && mv[ix] && (mwa[ix] == wa);
        if (exp_hit) begin
            exp_data = md[ix];
            exp_resp = 2'b00;
            exp_hits++;
        end else begin
            exp_data = mem_rd(wa);
            exp_resp = err_next ? 2'b10 : 2'b00;
            if (cach) exp_misses++;
            if (cach && !err_next && !(f_seen && f_miss)) begin
                mv[ix]  = 1'b1;
                mwa[ix] = wa;
                md[ix]  = exp_data;
            end
        end
        if (f_seen && !f_lookup) clear_model();
        if (exp_hit) chk("hit_latency", n, 2);
        else         chk("miss_latency_ge5", n >= 5, 1);
        chk("rdata", s_rdata, exp_data);
        chk("rresp", s_rresp, exp_resp);
        chk("rid_rlast", {s_rid, s_rlast}, {id, 1'b1});
        held = s_rdata;
        last_data = s_rdata;
        last_resp = s_rresp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            fence_i = 1'b0;
            chk("hold_stable", {s_rvalid, s_arready, s_rdata}, {1'b1, 1'b0, held});
        end
        s_rready = 1'b1;
        @(negedge clk);
        fence_i  = 1'b0;
        s_rready = 1'b0;
        chk("r_done", {s_rvalid, s_arready}, 2'b01);
        chk("fetch_count", ar_cnt - ar0, exp_hit ? 0 : 1);
        if (!exp_hit) chk("fetch_addr_id", {ar_addr_seen, ar_id_seen}, {wa, 2'b00, id});
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("miss_cnt", miss_cnt, exp_misses);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        logic [31:0] a;
        logic [29:0] k;
        int fk;
        clear_model();
        mem[30'h20000000] = 32'h00000413;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_s_side", {s_arready, s_rvalid, s_rlast, s_rdata, s_rresp, s_rid},
            {1'b1, 1'b0, 1'b1, 32'h0, 2'b00, 4'h0});
        chk("reset_m_side", {m_arvalid, m_rready, m_araddr, m_arid}, {1'b0, 1'b0, 32'h0, 4'h0});
        chk("reset_m_const", {m_arlen, m_arsize, m_arburst}, {8'h00, 3'b010, 2'b01});
        chk("reset_counters", {hit_cnt, miss_cnt}, 64'h0);

        do_read(32'h80000000, 0, 0);
        chk("cold_data", last_data, 32'h00000413);
        chk("cold_counts", {hit_cnt, miss_cnt}, {32'd0, 32'd1});
        a0 = ar_cnt;
        do_read(32'h80000000, 0, 0);
        chk("hit_no_fetch", ar_cnt - a0, 0);
        chk("hit_counts", {hit_cnt, last_data}, {32'd1, 32'h00000413});

        do_read(32'h80000040, 0, 0);
        do_read(32'h80000000, 0, 0);
        chk("conflict_misses", miss_cnt, 3);

        a0 = ar_cnt;
        do_read(32'ha0000048, 0, 0);
        do_read(32'ha0000048, 0, 0);
        chk("uncached_fetches", ar_cnt - a0, 2);
        chk("uncached_counts", {hit_cnt, miss_cnt}, {32'd1, 32'd3});

        do_read(32'h80000004, 0, 0);
        @(negedge clk);
        pulse_fence();
        a0 = ar_cnt;
        do_read(32'h80000004, 0, 0);
        chk("fence_idle_refetch", ar_cnt - a0, 1);

        do_read(32'h80000008, -1, 0);
        a0 = ar_cnt;
        do_read(32'h80000008, 0, 5);
        chk("fence_miss_r_refetch", ar_cnt - a0, 1);

        err_next = 1'b1;
        do_read(32'h8000000c, 0, 0);
        err_next = 1'b0;
        chk("err_forwarded", last_resp, 2'b10);
        a0 = ar_cnt;
        do_read(32'h8000000c, 0, 0);
        chk("err_not_filled", ar_cnt - a0, 1);

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0: a = 32'ha0000000 + 32'($urandom_range(0, 15)) * 4;
                1: case ($urandom_range(0, 3))
                       0: a = 32'h87fffffc;
                       1: a = 32'h88000000;
                       2: a = 32'h7ffffffc;
                       default: a = 32'h80000000;
                   endcase
                default: a = 32'h80000000 + 32'($urandom_range(0, 47)) * 4;
            endcase
            a[1:0] = 2'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                k = 30'h20000000 + 30'($urandom_range(0, 47));
                mem[k] = $urandom;
            end
            if ($urandom_range(0, 19) == 0) pulse_fence();
            case ($urandom_range(0, 9))
                0: fk = $urandom_range(1, 8);
                1: fk = -1;
                default: fk = 0;
            endcase
            err_next = ($urandom_range(0, 9) == 0);
            do_read(a, fk, $urandom_range(0, 3));
            err_next = 1'b0;
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        chk("rst_counters", {hit_cnt, miss_cnt}, 64'h0);
        a0 = ar_cnt;
        do_read(32'h80000000, 0, 0);
        chk("rst_invalidates", ar_cnt - a0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_25020032_icache.md
Name: ysyx_25020032_icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IFU's AXI read-address/read-data master port and the system AXI read bus.
- Acts as an AXI read slave to the IFU and as an AXI read master downstream.
- Hits return without bus traffic. Misses issue a single-beat fetch, fill the line and forward the word.
- Supports fence.i invalidation, an uncached address window, and hit/miss performance counters.

Parameters:
- INDEX_BITS, 4: line index width; 2^INDEX_BITS lines of 32 bits. Tag width = 30 - INDEX_BITS.
- CACHE_LO, 32'h80000000: lowest cacheable address, inclusive.
- CACHE_HI, 32'h87ffffff: highest cacheable address, inclusive. Addresses outside the range bypass the cache and are never filled.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_arvalid in 1 / s_arready out 1 / s_araddr in 32 / s_arid in 4 / s_arlen in 8 / s_arsize in 3 / s_arburst in 2: upstream AR channel.
- s_rvalid out 1 / s_rready in 1 / s_rdata out 32 / s_rresp out 2 / s_rlast out 1 / s_rid out 4: upstream R channel.
- m_arvalid out 1 / m_arready in 1 / m_araddr out 32 / m_arid out 4 / m_arlen out 8 / m_arsize out 3 / m_arburst out 2: downstream AR channel.
- m_rvalid in 1 / m_rready out 1 / m_rdata in 32 / m_rresp in 2 / m_rlast in 1 / m_rid in 4: downstream R channel.
- fence_i  in  1  invalidate all lines; single-cycle pulse.
- hit_cnt  out  32  count of cached hits; wraps at 2^32.
- miss_cnt  out  32  count of cacheable misses; wraps at 2^32.

Behaviour:
- States: IDLE, LOOKUP, MISS_AR, MISS_R, RESP. Reset state is IDLE.
- Reset values: all valid bits 0; s_rvalid, m_arvalid, m_rready, s_rdata, s_rresp, m_araddr = 0; s_rlast = 1; s_rid, m_arid = 0; counters 0.
- s_arready = (state == IDLE), combinational. It is therefore 1 one cycle after rst deasserts.
- m_arlen = 0, m_arsize = 3'b010, m_arburst = 2'b01, always.
- IDLE: on s_arvalid && s_arready, latch s_araddr and s_arid, then go to LOOKUP. s_arlen, s_arsize and s_arburst are ignored; only single-beat 4-byte reads are supported.
- LOOKUP: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]; addr[1:0] is ignored.
  - Cacheable and valid and tag match: load s_rdata from the line, s_rresp = OKAY, hit_cnt += 1, go to RESP.
  - Otherwise: m_araddr = {addr[31:2], 2'b00}, m_arid = latched id, m_arvalid = 1, go to MISS_AR. miss_cnt += 1 only if the address is cacheable.
- MISS_AR: hold m_arvalid and m_araddr stable until m_arready. On the handshake, m_arvalid <= 0, m_rready <= 1, go to MISS_R.
- MISS_R: on m_rvalid && m_rready:
  - m_rready <= 0; s_rdata <= m_rdata; s_rresp <= m_rresp; go to RESP.
  - The line is written (valid, tag, data) only if cacheable, m_rresp == 2'b00, and no fence_i was seen since the AR was accepted.
  - An error response is forwarded and the line is not filled.
- RESP: s_rvalid = 1, s_rid = latched id, s_rlast = 1. Hold all R outputs stable until s_rready, then s_rvalid <= 0 and go to IDLE.
- Latency, measured from the upstream AR handshake at cycle 0:
  - Hit: s_rvalid first high at cycle 2.
  - Miss with downstream m_arready and m_rvalid each 1-cycle responsive: s_rvalid at cycle 5 or later.
- fence_i clears all valid bits in the cycle it is sampled, in any state.
  - In LOOKUP, the lookup in that same cycle is treated as a miss.
  - During MISS_AR or MISS_R, a pending-fence flag is set; it suppresses the fill, and the data is still forwarded. The flag clears on entering IDLE.
- Only one transaction is outstanding. No new AR is accepted until the R handshake completes.
- Downstream m_rid and m_rlast are ignored.
- rst mid-transaction returns to IDLE and clears all valid bits and counters. Any in-flight downstream response after reset is not tracked; the downstream is reset by the same rst.

Test Plan:
- Cold miss: after reset, AR 0x80000000; memory returns 0x00000413 OKAY -> one m_ar at 0x80000000; s_rdata = 0x00000413, rresp 0; miss_cnt = 1, hit_cnt = 0.
- Hit: repeat AR 0x80000000 -> no m_arvalid; s_rvalid at cycle 2 with 0x00000413; hit_cnt = 1.
- Conflict: with INDEX_BITS=4, AR 0x80000040 (same index 0, different tag), then AR 0x80000000 -> both miss; miss_cnt = 3 total; second refetches.
- Uncached: AR 0xa0000048 twice -> two downstream fetches; neither hit_cnt nor miss_cnt changes.
- fence_i: fill 0x80000004, pulse fence_i while idle, then AR 0x80000004 -> downstream refetch. Also pulse fence_i during MISS_R -> data forwarded, next access to the same address misses again.
- Backpressure/error: hold s_rready = 0 for 5 cycles -> s_rvalid/s_rdata stable, s_arready = 0. Downstream rresp = 2'b10 -> forwarded as s_rresp = 2'b10; the next access to the same address misses.
